// File: rtl/seg_scan_if.sv
// Bundle between score logic (master) and the seven-segment scan driver (slave).
// SEG_SCAN_DIM_EN adds the bright input to the bundle.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int CAT_WIDTH  = 8
);
  logic [NUM_DIGITS-1:0][3:0] value;
  logic [NUM_DIGITS-1:0]      dp;
  logic                       hex_mode;
  logic                       lzb;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]                 bright;
`endif
  logic [CAT_WIDTH-1:0]       cat;
  logic [7:0]                 seg;
  logic                       frame_done;

`ifdef SEG_SCAN_DIM_EN
  modport master (output value, dp, hex_mode, lzb, bright, input cat, seg, frame_done);
  modport slave  (input value, dp, hex_mode, lzb, bright, output cat, seg, frame_done);
`else
  modport master (output value, dp, hex_mode, lzb, input cat, seg, frame_done);
  modport slave  (input value, dp, hex_mode, lzb, output cat, seg, frame_done);
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// N-digit time-multiplexed common-cathode seven-segment scanner with frame snapshot.
// Optional macro SEG_SCAN_DIM_EN adds a 16-level brightness (duty) control.
module seg_scan_digit (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [7:0] pat
);
  logic [6:0] dec;

  always_comb begin
    dec = 7'h00;
    case (nib)
      4'h0: dec = 7'h3F;
      4'h1: dec = 7'h06;
      4'h2: dec = 7'h5B;
      4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;
      4'h5: dec = 7'h6D;
      4'h6: dec = 7'h7D;
      4'h7: dec = 7'h27;
      4'h8: dec = 7'h7F;
      4'h9: dec = 7'h67;
      4'hA: dec = 7'h77;
      4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;
      4'hD: dec = 7'h5E;
      4'hE: dec = 7'h79;
      4'hF: dec = 7'h71;
      default: dec = 7'h00;
    endcase
    if (!hex_mode && nib > 4'd9) dec = 7'h40;
    if (blank) dec = 7'h00;
    pat = {dp, dec};
  end
endmodule

module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int CAT_WIDTH    = 8,
  parameter int SCAN_DIV     = 64,
  parameter int BLANK_CYCLES = 1
) (
  input logic      clk,
  input logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_START = CW'(SCAN_DIV - BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX     = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx, idx_nxt;
  logic [CAT_WIDTH-1:0]       cat_q, cat_nxt;
  logic [7:0]                 seg_q, pat_q, pat_sel;
  logic                       fd_q;
  logic [NUM_DIGITS-1:0][3:0] sh_val;
  logic [NUM_DIGITS-1:0]      sh_dp;
  logic                       sh_hex, sh_lzb;
  logic [NUM_DIGITS-1:0]      blk;
  logic [NUM_DIGITS-1:0][7:0] pat_all;
  logic                       slot_start, frame_start, lit, seen;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]                 sh_bright, bright_eff;
  logic [31:0]                dim_lhs, dim_rhs;
`endif

  assign slot_start  = (cnt == '0);
  assign frame_start = slot_start && (idx == IDX_MAX);
  assign idx_nxt     = (idx == IDX_MAX) ? '0 : idx + 1'b1;

  // Leading-zero flags come from the snapshot; digit 0 is never blanked.
  always_comb begin
    blk  = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen   = seen | (|sh_val[i]);
      blk[i] = sh_lzb & ~seen;
    end
  end

  // Digit 0 decodes the live inputs because it is only shown on the frame-start
  // edge, the same edge that loads the snapshot the other digits read.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_live
      seg_scan_digit u_dig (
        .nib(bus.value[0]), .dp(bus.dp[0]), .hex_mode(bus.hex_mode),
        .blank(1'b0), .pat(pat_all[g])
      );
    end else begin : g_shadow
      seg_scan_digit u_dig (
        .nib(sh_val[g]), .dp(sh_dp[g]), .hex_mode(sh_hex),
        .blank(blk[g]), .pat(pat_all[g])
      );
    end
  end

  assign pat_sel = pat_all[idx_nxt];

  always_comb begin
    cat_nxt          = '1;
    cat_nxt[idx_nxt] = 1'b0;
  end

  always_comb begin
    lit = 1'b1;
    if (BLANK_CYCLES != 0 && cnt >= BLANK_START) lit = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    bright_eff = frame_start ? bus.bright : sh_bright;
    dim_lhs    = 32'(cnt) << 4;
    dim_rhs    = (32'(bright_eff) + 32'd1) * 32'(SCAN_DIV - BLANK_CYCLES);
    if (dim_lhs >= dim_rhs) lit = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= IDX_MAX;
      cat_q     <= '1;
      seg_q     <= 8'h00;
      pat_q     <= 8'h00;
      fd_q      <= 1'b0;
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_hex    <= 1'b0;
      sh_lzb    <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      sh_bright <= 4'h0;
`endif
    end else begin
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      fd_q <= (cnt == CNT_MAX) && (idx == IDX_MAX);
      if (slot_start) begin
        idx   <= idx_nxt;
        cat_q <= cat_nxt;
        pat_q <= pat_sel;
      end
      if (frame_start) begin
        sh_val    <= bus.value;
        sh_dp     <= bus.dp;
        sh_hex    <= bus.hex_mode;
        sh_lzb    <= bus.lzb;
`ifdef SEG_SCAN_DIM_EN
        sh_bright <= bus.bright;
`endif
      end
      seg_q <= lit ? (slot_start ? pat_sel : pat_q) : 8'h00;
    end
  end

  assign bus.cat        = cat_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised time-multiplexed seven-segment display driver. It generalises the fixed two-digit scanner to N digits with a configurable scan rate and anti-ghost blanking window. It adds hex/decimal modes, per-digit decimal points, leading-zero blanking, and a frame-coherent value snapshot. It sits between game/score logic and the board's common-cathode segment and digit-select pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..CAT_WIDTH)
CAT_WIDTH, 8, width of digit-select bus; bits at or above NUM_DIGITS are held 1 (off)
SCAN_DIV, 64, clock cycles per digit slot (>=2)
BLANK_CYCLES, 1, cycles at the end of each slot with segments forced off (0..SCAN_DIV-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  packed nibbles; nibble i shown on digit i; nibble 0 is least significant
dp  in  NUM_DIGITS  per-digit decimal point, 1 = lit
hex_mode  in  1  1 = nibbles 0-F as hex; 0 = decimal, nibbles >9 show dash
lzb  in  1  1 = blank leading zero digits
cat  out  CAT_WIDTH  digit select, active-low, one-cold
seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high, registered
frame_done  out  1  one-cycle pulse at the end of the last digit slot

Behaviour:
- Reset values (async, immediate): cat = all 1s, seg = 8'h00, frame_done = 0, slot counter = 0, digit index = NUM_DIGITS-1, shadow registers = 0.
- Slot counter counts 0..SCAN_DIV-1 and wraps. On the edge where the counter is 0, the digit index advances, wrapping NUM_DIGITS-1 -> 0.
- cat and seg load on that same edge.
- The first rising edge after reset release is a counter==0 edge and selects digit 0.
- Frame start occurs when the index wraps to 0. On that edge, value, dp, hex_mode and lzb are captured into shadow registers.
- Digit 0 of the frame decodes directly from the live inputs at that edge. Digits 1..N-1 decode from the shadow. Input changes mid-frame never alter the frame in progress.
- Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=27, 8=7F, 9=67, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Decimal mode: nibble 10..15 decodes to 8'h40 (dash).
- seg[7] = dp bit of the selected digit, ORed over the decoded pattern bits [6:0].
- Leading-zero blanking: when lzb=1, every digit above the most significant nonzero nibble has seg[6:0]=0. Its dp still shows.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Blank window: while counter >= SCAN_DIV-BLANK_CYCLES, seg = 8'h00. cat stays on the current digit.
  - BLANK_CYCLES=0 means segments are never blanked.
- Segments go to 0 no later than the edge before cat changes, so no ghosting with BLANK_CYCLES>=1.
- frame_done = 1 for exactly one cycle, registered, when counter==SCAN_DIV-1 and index==NUM_DIGITS-1.
- NUM_DIGITS=1: cat[0] stays low after the first edge, and every slot is a frame start.
- Counter width is $clog2(SCAN_DIV). No arithmetic overflow is possible.

Optional Feature:
- Macro SEG_SCAN_DIM_EN, when defined:
  - Adds input bright [3:0].
  - Within each slot, seg is forced to 0 unless counter*16 < (bright+1)*(SCAN_DIV-BLANK_CYCLES).
  - bright=15 gives the full non-blank window; bright=0 gives about 1/16 duty.
  - bright is captured at frame start with the other shadows.
- When undefined: the port is absent and segments are lit for the full non-blank window.

Test Plan:
All scenarios use NUM_DIGITS=4, CAT_WIDTH=8, SCAN_DIV=8, BLANK_CYCLES=1.
1. Reset: rst_n=0 at any time -> cat=8'hFF, seg=8'h00, frame_done=0 in the same cycle, without waiting for clk.
2. Hex scan: value=16'h12AF, hex_mode=1, dp=0, release reset.
   - Edge 1: cat=FE, seg=71; edge 8: seg=00.
   - Edge 9: cat=FD, seg=77; then cat=FB/seg=5B, then cat=F7/seg=06.
   - frame_done high at edge 32 only.
3. Decimal mode: value=16'h9A05, hex_mode=0 -> slots show 6D, 3F, 40, 67 on digits 0..3.
4. Leading zero plus dp: value=16'h0050, lzb=1, dp=4'b0100 -> digit0=3F, digit1=6D, digit2=80, digit3=00.
5. Snapshot: value=16'h1234 at frame start, changed to 16'h5678 at edge 10.
   - Digits 1..3 of the current frame show 4F, 5B, 06.
   - The next frame shows 7F, 27, 7D, 6D.
6. Reset mid-slot: assert rst_n=0 at edge 13, release at edge 15.
   - cat=FF and seg=00 while in reset.
   - The first edge after release shows digit 0 with cat=FE.
